// File: rtl/pmu_pkg.sv
// Shared definitions for the PMU counter bank: group indices, the counter
// address map and the per-vector event classifier.
package pmu_pkg;

   // Widest lane vector the classifier accepts; narrower vectors are zero-extended.
   localparam int MAX_LANES  = 32;
   localparam int LANE_IDX_W = 5;

   // Event groups, in address-map order.
   localparam int NUM_GROUPS = 4;
   localparam int GRP_ARRIVE = 0;
   localparam int GRP_DISC   = 1;
   localparam int GRP_TRX    = 2;
   localparam int GRP_IO     = 3;

   // Fixed counters, followed by NUM_GROUPS blocks of NUM_LANES lane counters.
   localparam int ADDR_TOTAL_REQ = 0;
   localparam int ADDR_UNREC_CMD = 1;
   localparam int ADDR_UNREC_TRX = 2;
   localparam int ADDR_UNREC_IO  = 3;
   localparam int ADDR_LANE_BASE = 4;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_LANE,
      EV_UNREC
   } event_kind_e;

   typedef struct packed {
      event_kind_e             kind;
      logic [LANE_IDX_W-1:0]   lane;
   } event_class_t;

   // No bit set: no event. One bit set: that lane. Two or more: unrecoverable.
   function automatic event_class_t classify(input logic [MAX_LANES-1:0] vec);
      event_class_t res;
      int unsigned  cnt;
      res.kind = EV_NONE;
      res.lane = '0;
      cnt      = 0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (vec[i]) begin
            cnt++;
            res.lane = LANE_IDX_W'(i);
         end
      end
      if (cnt == 1)
         res.kind = EV_LANE;
      else if (cnt >= 2)
         res.kind = EV_UNREC;
      return res;
   endfunction

   // Sticky saturation flag after one clock: any clear drops it, an increment
   // arriving while the counter is already all-ones raises it.
   function automatic logic sat_next(input logic sat, input logic full,
                                     input logic inc, input logic clr,
                                     input logic rd_clr);
      if (clr || rd_clr)
         return 1'b0;
      return sat | (inc & full);
   endfunction

endpackage

// File: rtl/pmu_sat_counter.sv
// Single saturating event counter with sticky saturation flag, global clear
// and clear-on-read. A read-clear that coincides with an increment keeps the
// new event, so the counter restarts at 1.
module pmu_sat_counter
   import pmu_pkg::*;
#(
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_inc,
   input  logic                     i_clr,
   input  logic                     i_rd_clr,
   output logic [COUNTER_WIDTH-1:0] o_value,
   output logic                     o_sat
);

   logic [COUNTER_WIDTH-1:0] r_value;
   logic                     r_sat;
   logic                     w_full;

   assign w_full  = &r_value;
   assign o_value = r_value;
   assign o_sat   = r_sat;

   // Counter state: rst > clear_all > read-clear > increment.
   always_ff @(posedge clk) begin
      // NOTE: state is written with <= so every flop samples pre-edge values;
      // blocking here would let later statements see already-updated state.
      if (rst) begin
         r_value <= '0;
         r_sat   <= 1'b0;
      end else begin
         if (i_clr)
            r_value <= '0;
         else if (i_rd_clr)
            r_value <= COUNTER_WIDTH'(i_inc);
         else if (i_inc && !w_full)
            r_value <= r_value + COUNTER_WIDTH'(1);
         r_sat <= sat_next(r_sat, w_full, i_inc, i_clr, i_rd_clr);
      end
   end

endmodule

// File: rtl/pmu_counter_bank.sv
// Performance-monitoring counter bank for the redundant-lane controller:
// classifies per-lane event vectors, drives one saturating counter per
// address and serves a one-cycle-latency registered read port.
module pmu_counter_bank
   import pmu_pkg::*;
#(
   parameter int NUM_LANES     = 3,
   parameter int COUNTER_WIDTH = 16,
   parameter int ADDR_WIDTH    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_LANES-1:0]     i_trx_error,
   input  logic [NUM_LANES-1:0]     i_io_error,
   input  logic [NUM_LANES-1:0]     i_cmd_arrive,
   input  logic [NUM_LANES-1:0]     i_cmd_discrepancy,
   input  logic                     i_count_en,
   input  logic                     i_clear_all,
   input  logic                     i_rd_req,
   input  logic [ADDR_WIDTH-1:0]    i_rd_addr,
   input  logic                     i_rd_clear,
   output logic                     o_rd_valid,
   output logic [COUNTER_WIDTH-1:0] o_rd_data,
   output logic                     o_rd_sat,
   output logic                     o_rd_err,
   output logic                     o_any_sat
);

   localparam int NUM_CTRS = ADDR_LANE_BASE + NUM_GROUPS * NUM_LANES;

   logic [NUM_LANES-1:0]     w_grp_vec [NUM_GROUPS];
   logic [NUM_CTRS-1:0]      w_inc;
   logic [NUM_CTRS-1:0]      w_rd_clr;
   logic [NUM_CTRS-1:0]      w_sat;
   logic [NUM_CTRS-1:0]      w_sat_nxt;
   logic [COUNTER_WIDTH-1:0] w_value [NUM_CTRS];
   logic [COUNTER_WIDTH-1:0] w_rd_value;
   logic                     w_rd_sat;
   logic                     w_in_range;

   logic                     r_rd_valid;
   logic [COUNTER_WIDTH-1:0] r_rd_data;
   logic                     r_rd_sat;
   logic                     r_rd_err;
   logic                     r_any_sat;

   assign w_grp_vec[GRP_ARRIVE] = i_cmd_arrive;
   assign w_grp_vec[GRP_DISC]   = i_cmd_discrepancy;
   assign w_grp_vec[GRP_TRX]    = i_trx_error;
   assign w_grp_vec[GRP_IO]     = i_io_error;

   // Event classification into per-counter increment strobes.
   always_comb begin
      event_class_t v_cls;
      // NOTE: every always_comb output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_inc = '0;
      v_cls = '0;
      if (i_count_en) begin
         // Arrivals count every set lane plus one total per cycle.
         w_inc[ADDR_TOTAL_REQ] = |w_grp_vec[GRP_ARRIVE];
         for (int l = 0; l < NUM_LANES; l++)
            w_inc[ADDR_LANE_BASE + GRP_ARRIVE * NUM_LANES + l] = w_grp_vec[GRP_ARRIVE][l];
         // Other groups: a single lane hits its lane counter, a multi-lane
         // event hits only the group's unrecoverable counter.
         for (int g = GRP_DISC; g < NUM_GROUPS; g++) begin
            v_cls = classify(MAX_LANES'(w_grp_vec[g]));
            if (v_cls.kind == EV_UNREC) begin
               w_inc[ADDR_UNREC_CMD + g - GRP_DISC] = 1'b1;
            end else if (v_cls.kind == EV_LANE) begin
               for (int l = 0; l < NUM_LANES; l++)
                  if (v_cls.lane == LANE_IDX_W'(l))
                     w_inc[ADDR_LANE_BASE + g * NUM_LANES + l] = 1'b1;
            end
         end
      end
   end

   // Read address decode: selected value/flag and per-counter read-clear.
   always_comb begin
      w_rd_value = '0;
      w_rd_sat   = 1'b0;
      w_in_range = 1'b0;
      w_rd_clr   = '0;
      for (int i = 0; i < NUM_CTRS; i++) begin
         if (i_rd_addr == ADDR_WIDTH'(i)) begin
            w_in_range  = 1'b1;
            w_rd_value  = w_value[i];
            w_rd_sat    = w_sat[i];
            w_rd_clr[i] = i_rd_req & i_rd_clear;
         end
      end
   end

   for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
      pmu_sat_counter #(
         .COUNTER_WIDTH (COUNTER_WIDTH)
      ) u_ctr (
         .clk      (clk),
         .rst      (rst),
         .i_inc    (w_inc[i]),
         .i_clr    (i_clear_all),
         .i_rd_clr (w_rd_clr[i]),
         .o_value  (w_value[i]),
         .o_sat    (w_sat[i])
      );
      // Flag value the counter will hold after this edge, for any_sat.
      assign w_sat_nxt[i] = sat_next(w_sat[i], &w_value[i], w_inc[i],
                                     i_clear_all, w_rd_clr[i]);
   end

   // Registered read response and aggregate saturation flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_sat   <= 1'b0;
         r_rd_err   <= 1'b0;
         r_any_sat  <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_req;
         if (i_rd_req) begin
            r_rd_data <= w_rd_value;
            r_rd_sat  <= w_rd_sat;
            r_rd_err  <= ~w_in_range;
         end
         r_any_sat <= |w_sat_nxt;
      end
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_rd_sat   = r_rd_sat;
   assign o_rd_err   = r_rd_err;
   assign o_any_sat  = r_any_sat;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Self-checking bench for pmu_counter_bank (3 lanes, 4-bit counters so that
// saturation is reachable). A per-counter reference model tracks the
// expected counter contents and read-port outputs cycle by cycle.
module tb_pmu_counter_bank;

   localparam int NL   = 3;
   localparam int CW   = 4;
   localparam int AW   = 5;
   localparam int NC   = 4 + 4 * NL;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic [NL-1:0] trx, io, arr, disc;
   logic          count_en, clear_all, rd_req, rd_clear;
   logic [AW-1:0] rd_addr;
   logic          rd_valid, rd_sat, rd_err, any_sat;
   logic [CW-1:0] rd_data;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int            m_cnt [NC];
   bit            m_flag [NC];
   logic          m_valid, m_rsat, m_err, m_any;
   logic [CW-1:0] m_data;

   pmu_counter_bank #(
      .NUM_LANES     (NL),
      .COUNTER_WIDTH (CW),
      .ADDR_WIDTH    (AW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_trx_error       (trx),
      .i_io_error        (io),
      .i_cmd_arrive      (arr),
      .i_cmd_discrepancy (disc),
      .i_count_en        (count_en),
      .i_clear_all       (clear_all),
      .i_rd_req          (rd_req),
      .i_rd_addr         (rd_addr),
      .i_rd_clear        (rd_clear),
      .o_rd_valid        (rd_valid),
      .o_rd_data         (rd_data),
      .o_rd_sat          (rd_sat),
      .o_rd_err          (rd_err),
      .o_any_sat         (any_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // One clock of the behavioural model, applied to the inputs seen at the edge.
   task automatic model_step();
      bit            ev [NC];
      logic [NL-1:0] vv [4];
      int            n;
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            m_cnt[i]  = 0;
            m_flag[i] = 0;
         end
         m_valid = 0; m_data = '0; m_rsat = 0; m_err = 0; m_any = 0;
         return;
      end
      // Response shows counter contents before this edge's update.
      m_valid = rd_req;
      if (rd_req) begin
         if (rd_addr < NC) begin
            m_data = CW'(m_cnt[rd_addr]);
            m_rsat = m_flag[rd_addr];
            m_err  = 0;
         end else begin
            m_data = '0;
            m_rsat = 0;
            m_err  = 1;
         end
      end
      for (int i = 0; i < NC; i++) ev[i] = 0;
      vv[0] = arr; vv[1] = disc; vv[2] = trx; vv[3] = io;
      if (count_en) begin
         if (arr != 0) ev[0] = 1;
         for (int l = 0; l < NL; l++) if (arr[l]) ev[4 + l] = 1;
         for (int g = 1; g < 4; g++) begin
            n = $countones(vv[g]);
            if (n >= 2) ev[g] = 1;
            else if (n == 1)
               for (int l = 0; l < NL; l++) if (vv[g][l]) ev[4 + g * NL + l] = 1;
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (clear_all) begin
            m_cnt[i] = 0; m_flag[i] = 0;
         end else if (rd_req && rd_clear && rd_addr == i) begin
            m_cnt[i] = ev[i] ? 1 : 0; m_flag[i] = 0;
         end else if (ev[i]) begin
            if (m_cnt[i] == CMAX) m_flag[i] = 1;
            else m_cnt[i] = m_cnt[i] + 1;
         end
      end
      m_any = 0;
      for (int i = 0; i < NC; i++) m_any = m_any | m_flag[i];
   endtask

   // Advance one clock; outputs are stable 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Issue one read and return the response observed one cycle later.
   task automatic rd(input int addr, input bit clr, output logic v,
                     output logic [CW-1:0] d, output logic s, output logic e);
      rd_req   = 1'b1;
      rd_addr  = AW'(addr);
      rd_clear = clr;
      tick();
      v = rd_valid; d = rd_data; s = rd_sat; e = rd_err;
      rd_req   = 1'b0;
      rd_clear = 1'b0;
   endtask

   task automatic idle_events();
      trx = '0; io = '0; arr = '0; disc = '0;
   endtask

   task automatic test_reset();
      logic v, s, e;
      logic [CW-1:0] d;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_checks++;
      if ({rd_valid, rd_data, rd_sat, rd_err, any_sat} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got v=%b d=%0d s=%b e=%b any=%b, want all 0",
                  rd_valid, rd_data, rd_sat, rd_err, any_sat);
      end
      for (int a = 0; a < NC; a++) begin
         rd(a, 0, v, d, s, e);
         n_checks++;
         if (v !== 1'b1 || d !== '0 || s !== 1'b0 || e !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctr%0d: got v=%b d=%0d s=%b e=%b, want v=1 d=0 s=0 e=0",
                     a, v, d, s, e);
         end
      end
   endtask

   task automatic test_arrive();
      logic v, s, e;
      logic [CW-1:0] d;
      int addrs [4] = '{0, 4, 5, 6};
      int want  [4] = '{3, 3, 0, 3};
      arr = 3'b101;
      repeat (3) tick();
      idle_events();
      for (int k = 0; k < 4; k++) begin
         rd(addrs[k], 0, v, d, s, e);
         n_checks++;
         if (v !== 1'b1 || d !== CW'(want[k]) || e !== 1'b0) begin
            n_errors++;
            $display("FAIL arrive_addr%0d: got v=%b d=%0d e=%b, want v=1 d=%0d e=0",
                     addrs[k], v, d, e, want[k]);
         end
      end
      // rd_valid is a single-cycle pulse; data holds until the next response.
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== CW'(3)) begin
         n_errors++;
         $display("FAIL arrive_hold: got v=%b d=%0d, want v=0 d=3", rd_valid, rd_data);
      end
   endtask

   task automatic test_trx_io();
      logic v, s, e;
      logic [CW-1:0] d;
      int addrs [4] = '{11, 2, 15, 3};
      int want  [4] = '{2, 1, 1, 0};
      trx = 3'b010; io = 3'b100; tick();
      io  = 3'b000;              tick();
      trx = 3'b011;              tick();
      idle_events();
      for (int k = 0; k < 4; k++) begin
         rd(addrs[k], 0, v, d, s, e);
         n_checks++;
         if (v !== 1'b1 || d !== CW'(want[k]) || e !== 1'b0) begin
            n_errors++;
            $display("FAIL trx_io_addr%0d: got v=%b d=%0d e=%b, want v=1 d=%0d e=0",
                     addrs[k], v, d, e, want[k]);
         end
      end
   endtask

   task automatic test_saturation();
      logic v, s, e;
      logic [CW-1:0] d;
      disc = 3'b001;
      repeat (20) tick();
      idle_events();
      n_checks++;
      if (any_sat !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_any_set: got any_sat=%b, want 1", any_sat);
      end
      rd(7, 0, v, d, s, e);
      n_checks++;
      if (v !== 1'b1 || d !== CW'(CMAX) || s !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_read: got v=%b d=%0d s=%b, want v=1 d=%0d s=1", v, d, s, CMAX);
      end
      rd(7, 1, v, d, s, e);
      n_checks++;
      if (d !== CW'(CMAX) || s !== 1'b1 || any_sat !== 1'b0) begin
         n_errors++;
         $display("FAIL sat_rdclr: got d=%0d s=%b any=%b, want d=%0d s=1 any=0",
                  d, s, any_sat, CMAX);
      end
      rd(7, 0, v, d, s, e);
      n_checks++;
      if (d !== '0 || s !== 1'b0) begin
         n_errors++;
         $display("FAIL sat_after_clr: got d=%0d s=%b, want d=0 s=0", d, s);
      end
   endtask

   task automatic test_rdclr_event();
      logic v, s, e;
      logic [CW-1:0] d;
      arr = 3'b001;
      repeat (6) tick();            // addr4: 3 -> 9
      rd(4, 1, v, d, s, e);         // arrival still asserted this cycle
      idle_events();
      n_checks++;
      if (v !== 1'b1 || d !== CW'(9)) begin
         n_errors++;
         $display("FAIL rdclr_evt_first: got v=%b d=%0d, want v=1 d=9", v, d);
      end
      rd(4, 0, v, d, s, e);
      n_checks++;
      if (d !== CW'(1) || s !== 1'b0) begin
         n_errors++;
         $display("FAIL rdclr_evt_reread: got d=%0d s=%b, want d=1 s=0", d, s);
      end
   endtask

   task automatic test_freeze();
      logic v, s, e;
      logic [CW-1:0] d;
      int snap [NC];
      bit snap_f [NC];
      bit snap_any;
      for (int i = 0; i < NC; i++) begin
         snap[i]   = m_cnt[i];
         snap_f[i] = m_flag[i];
      end
      snap_any = m_any;
      count_en = 1'b0;
      repeat (5) begin
         arr  = NL'($urandom_range(1, 7));
         disc = NL'($urandom_range(1, 7));
         trx  = NL'($urandom_range(1, 7));
         io   = NL'($urandom_range(1, 7));
         tick();
      end
      idle_events();
      count_en = 1'b1;
      n_checks++;
      if (any_sat !== snap_any) begin
         n_errors++;
         $display("FAIL freeze_any: got %b, want %b", any_sat, snap_any);
      end
      for (int a = 0; a < NC; a++) begin
         rd(a, 0, v, d, s, e);
         n_checks++;
         if (d !== CW'(snap[a]) || s !== snap_f[a]) begin
            n_errors++;
            $display("FAIL freeze_ctr%0d: got d=%0d s=%b, want d=%0d s=%b",
                     a, d, s, snap[a], snap_f[a]);
         end
      end
      rd(20, 1, v, d, s, e);
      n_checks++;
      if (v !== 1'b1 || d !== '0 || s !== 1'b0 || e !== 1'b1) begin
         n_errors++;
         $display("FAIL out_of_range: got v=%b d=%0d s=%b e=%b, want v=1 d=0 s=0 e=1",
                  v, d, s, e);
      end
   endtask

   task automatic test_clear_all();
      logic v, s, e;
      logic [CW-1:0] d;
      arr = 3'b111; disc = 3'b011; trx = 3'b100; io = 3'b110;
      clear_all = 1'b1;
      tick();
      clear_all = 1'b0;
      idle_events();
      n_checks++;
      if (any_sat !== 1'b0) begin
         n_errors++;
         $display("FAIL clear_all_any: got %b, want 0", any_sat);
      end
      for (int a = 0; a < NC; a++) begin
         rd(a, 0, v, d, s, e);
         n_checks++;
         if (d !== '0 || s !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_all_ctr%0d: got d=%0d s=%b, want d=0 s=0", a, d, s);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 600; c++) begin
         arr       = NL'($urandom_range(0, 7));
         disc      = NL'($urandom_range(0, 7));
         trx       = NL'($urandom_range(0, 7));
         io        = NL'($urandom_range(0, 7));
         count_en  = ($urandom_range(0, 9) != 0);
         clear_all = ($urandom_range(0, 99) == 0);
         rd_req    = ($urandom_range(0, 3) != 0);
         rd_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(16, 31))
                                                 : AW'($urandom_range(0, 15));
         rd_clear  = ($urandom_range(0, 7) == 0);
         tick();
         n_checks++;
         if (rd_valid !== m_valid || rd_data !== m_data || rd_sat !== m_rsat ||
             rd_err !== m_err || any_sat !== m_any) begin
            n_errors++;
            $display("FAIL rand_cyc%0d: got v=%b d=%0d s=%b e=%b any=%b, want v=%b d=%0d s=%b e=%b any=%b",
                     c, rd_valid, rd_data, rd_sat, rd_err, any_sat,
                     m_valid, m_data, m_rsat, m_err, m_any);
         end
      end
      idle_events();
      count_en = 1'b1; clear_all = 1'b0; rd_req = 1'b0; rd_clear = 1'b0;
   endtask

   task automatic test_rst_outstanding();
      logic v, s, e;
      logic [CW-1:0] d;
      // Leave a nonzero response and a saturated counter behind first.
      disc = 3'b010;
      repeat (CMAX + 2) tick();
      idle_events();
      rd(8, 0, v, d, s, e);
      rd_req  = 1'b1;
      rd_addr = AW'(8);
      rst     = 1'b1;
      tick();
      rst     = 1'b0;
      rd_req  = 1'b0;
      n_checks++;
      if ({rd_valid, rd_data, rd_sat, rd_err, any_sat} !== '0) begin
         n_errors++;
         $display("FAIL rst_rd_outputs: got v=%b d=%0d s=%b e=%b any=%b, want all 0",
                  rd_valid, rd_data, rd_sat, rd_err, any_sat);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_rd_late_valid: got v=%b, want 0", rd_valid);
      end
      rd(8, 0, v, d, s, e);
      n_checks++;
      if (v !== 1'b1 || d !== '0 || s !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_rd_ctr8: got v=%b d=%0d s=%b, want v=1 d=0 s=0", v, d, s);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_events();
      count_en  = 1'b1;
      clear_all = 1'b0;
      rd_req    = 1'b0;
      rd_addr   = '0;
      rd_clear  = 1'b0;

      test_reset();
      test_arrive();
      test_trx_io();
      test_saturation();
      test_rdclr_event();
      test_freeze();
      test_clear_all();
      test_back_to_back();
      test_rst_outstanding();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
